// File: rtl/s526_bist_ctrl.sv
// BIST wrapper for the s526 benchmark: LFSR stimulus on g0..g2, MISR compaction of
// the six CUT responses, and a start/done handshake with a golden-signature compare.
module s526_bist_ctrl #(
    parameter int unsigned N_PAT     = 64,
    parameter int unsigned FLUSH_CYC = 4,
    parameter logic [15:0] LFSR_SEED = 16'h0001,
    parameter logic [15:0] MISR_SEED = 16'h0000,
    parameter logic [15:0] EXP_SIG   = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        g147,
    input  logic        g148,
    input  logic        g198,
    input  logic        g199,
    input  logic        g213,
    input  logic        g214,
    output logic        g0,
    output logic        g1,
    output logic        g2,
    output logic        busy,
    output logic        done,
    output logic [15:0] sig,
    output logic        pass
);
    // state  | meaning
    // IDLE   | after reset, CUT inputs held 0
    // FLUSH  | g0=1 for FLUSH_CYC cycles to initialise the CUT flops
    // RUN    | N_PAT LFSR patterns applied
    // DRAIN  | one cycle to capture the response to the last pattern
    // DONE   | signature held, pass valid, start reruns the test
    typedef enum logic [2:0] {S_IDLE, S_FLUSH, S_RUN, S_DRAIN, S_DONE} state_t;

    localparam logic [15:0] SEED_EFF   = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [15:0] FLUSH_LAST = 16'(FLUSH_CYC - 1);
    localparam logic [15:0] RUN_LAST   = 16'(N_PAT - 1);

    state_t      state, state_d;
    logic [15:0] cnt, cnt_d;
    logic [15:0] lfsr, lfsr_d;
    logic [15:0] misr_d;
    logic [2:0]  g_d;
    logic        busy_d, done_d, pass_d;
    logic [5:0]  resp;

    assign resp = {g214, g213, g199, g198, g148, g147};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:  if (start) state_d = S_FLUSH;
            S_FLUSH: if (cnt == FLUSH_LAST) state_d = S_RUN;
            S_RUN:   if (cnt == RUN_LAST) state_d = S_DRAIN;
            S_DRAIN: state_d = S_DONE;
            S_DONE:  if (start) state_d = S_FLUSH;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from the next-state view so they line up with the state.
    always_comb begin
        lfsr_d = lfsr;
        misr_d = sig;
        cnt_d  = cnt;
        if ((state == S_IDLE || state == S_DONE) && start) begin
            lfsr_d = SEED_EFF;
            misr_d = MISR_SEED;
        end else begin
            if (state == S_RUN)
                lfsr_d = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            // responses lag their pattern by one cycle, hence RUN cycle 0 is skipped
            if ((state == S_RUN && cnt != 16'd0) || state == S_DRAIN)
                misr_d = {sig[14:0], sig[15] ^ sig[13] ^ sig[12] ^ sig[10]} ^ {10'b0, resp};
        end
        if (state_d != state)
            cnt_d = 16'd0;
        else if (state == S_FLUSH || state == S_RUN)
            cnt_d = cnt + 16'd1;

        case (state_d)
            S_FLUSH: g_d = 3'b001;
            S_RUN:   g_d = lfsr_d[2:0];
            default: g_d = 3'b000;
        endcase
        busy_d = (state_d == S_FLUSH) || (state_d == S_RUN) || (state_d == S_DRAIN);
        done_d = (state_d == S_DONE);
        pass_d = (state_d == S_DONE) && (misr_d == EXP_SIG);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt          <= 16'd0;
            lfsr         <= SEED_EFF;
            sig          <= MISR_SEED;
            {g2, g1, g0} <= 3'b000;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
        end else begin
            cnt          <= cnt_d;
            lfsr         <= lfsr_d;
            sig          <= misr_d;
            {g2, g1, g0} <= g_d;
            busy         <= busy_d;
            done         <= done_d;
            pass         <= pass_d;
        end
    end
endmodule

// File: doc/s526_bist_ctrl.md
# s526_bist_ctrl

Built-in self-test wrapper for the s526 sequential benchmark. It drives the CUT primary inputs G0..G2 from a 16-bit pseudo-random pattern generator and compacts the six CUT outputs into a 16-bit MISR signature. A start/done handshake exposes the result and a pass/fail compare to the encrypted-domain evaluation flow. It sits on both sides of s526: upstream it feeds G0/G1/G2, and downstream it consumes G147/G148/G198/G199/G213/G214.

## Interface
- N_PAT, 64, number of patterns applied in RUN; legal range 1..65535.
- FLUSH_CYC, 4, cycles G0 is held high before RUN; legal range 1..255.
- LFSR_SEED, 16'h0001, pattern generator seed; the value 0 is treated as 16'h0001.
- MISR_SEED, 16'h0000, signature register initial value.
- EXP_SIG, 16'h0000, golden signature for PASS.
- CK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset, asynchronous, active-high.
- START  in  1  begin a test; sampled on CK in IDLE and DONE only.
- G0, G1, G2  out  1 each  CUT stimulus; registered.
- G147, G148, G198, G199, G213, G214  in  1 each  CUT responses.
- BUSY  out  1  high in FLUSH, RUN and DRAIN.
- DONE  out  1  high in the DONE state.
- SIG  out  16  MISR contents; meaningful when DONE=1.
- PASS  out  1  SIG==EXP_SIG, gated by DONE; 0 otherwise.

## Operation
- FSM states: IDLE, FLUSH, RUN, DRAIN, DONE; one-hot or binary encoding.
- IDLE: G0..G2 = 0. START=1 moves to FLUSH, reloads lfsr=LFSR_SEED and misr=MISR_SEED, and clears the counter.
- FLUSH: G0=1, G1=G2=0 for FLUSH_CYC cycles. No compaction.
- RUN: runs N_PAT cycles. In RUN cycle i (i=0..N_PAT-1), {G2,G1,G0} = lfsr[2:0]; the lfsr value is the seed shifted i times.
- LFSR update, applied each RUN cycle: lfsr <= {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}.
- Response vector r = {G214,G213,G199,G198,G148,G147}, mapped to bits 5..0.
- MISR update: misr <= {misr[14:0], misr[15]^misr[13]^misr[12]^misr[10]} ^ {10'b0, r}.
- MISR enable: RUN cycles 1..N_PAT-1 plus the single DRAIN cycle, for exactly N_PAT captures. Each response is captured one cycle after its pattern, because the CUT outputs are flop outputs.
- DRAIN: one cycle. G0..G2 = 0; final capture.
- DONE: DONE=1, SIG held, PASS valid. START=1 re-enters FLUSH, reseeds lfsr/misr, and drops DONE. START=0 stays in DONE. There is no return to IDLE except via RST.
- START while BUSY is ignored.
- Counter: 16-bit, shared by FLUSH and RUN, cleared on each state entry.

## Timing
- Reset values: state=IDLE, G0=G1=G2=0, BUSY=0, DONE=0, PASS=0, SIG=MISR_SEED, lfsr=LFSR_SEED, counter=0.
- RST asserted mid-test aborts immediately and asynchronously to the reset values. The CUT sees G0..G2=0; no partial signature is retained.
- With START sampled high at edge e0: FLUSH occupies [e0, e0+FLUSH_CYC), RUN occupies [e0+FLUSH_CYC, e0+FLUSH_CYC+N_PAT), DRAIN is one cycle, and DONE rises at e0+FLUSH_CYC+N_PAT+1.
- All outputs change only on CK edges, apart from the asynchronous reset; there is no combinational input-to-output path.
- N_PAT=1 is legal: RUN has one cycle with no compaction, and DRAIN performs the single capture.
- START held high continuously: one test per FLUSH_CYC+N_PAT+2 cycles; DONE lasts exactly one cycle per run.

## Test plan
- Reset/idle: assert RST mid-RUN (N_PAT=64, cycle 10) -> same cycle, G0..G2=0, BUSY=0, DONE=0, SIG=MISR_SEED. After release, the block stays in IDLE with START=0.
- Pattern sequence: LFSR_SEED=16'h0001, FLUSH_CYC=4 -> G0=1 for 4 cycles, then {G2,G1,G0} = 001, 010, 100, 000, ... until bit 10 reaches bit 15.
- Signature, constant response: responses tied 0, MISR_SEED=0, EXP_SIG=0, N_PAT=64 -> DONE at e0+69, SIG=16'h0000, PASS=1.
- Signature, single bit: G147=1 and other responses 0, MISR_SEED=0. N_PAT=1 -> SIG=16'h0001. N_PAT=2 -> SIG=16'h0003. With EXP_SIG=16'h0002 and N_PAT=2 -> PASS=0.
- Handshake: START pulses during BUSY are ignored. START in DONE restarts, with DONE low the next cycle. START held high gives a DONE pulse every FLUSH_CYC+N_PAT+2 cycles.
- Closed loop with the s526 netlist: LFSR_SEED=16'hACE1, N_PAT=255 -> SIG matches the golden signature from the reference simulation and is reproducible across two consecutive runs.
